// File: rtl/ps2_key_decoder.sv
// PS/2 key word decoder: waits for the receiver's {prev, last} byte pair to
// settle, classifies it as make/break/prefix, translates Set-2 make codes to
// ASCII and queues the characters in a small first-word-fall-through FIFO
// that the CPU drains through its MMIO keyboard port.
module ps2_key_decoder #(
    parameter int STABLE_CYCLES = 200000,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_W         = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_in,
    input  logic        rd_en,
    input  logic        ovf_clr,
    output logic [7:0]  data_out,
    output logic        valid,
    output logic        key_down,
    output logic [7:0]  held_code,
    output logic [3:0]  fifo_count,
    output logic        overflow
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]      DEPTH_C = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STABLE,
        S_DECODE
    } state_t;

    state_t             state;
    logic [15:0]        last_word;
    logic [15:0]        cand;
    logic [CNT_W-1:0]   cnt;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic [7:0]         hi;
    logic [7:0]         lo;
    logic               is_prefix;
    logic               is_break;
    logic               is_make;
    logic               new_make;
    logic [8:0]         map_res;
    logic               push;
    logic               pop;
    logic               full;

    // Set-2 make code to ASCII; bit 8 flags a mapped code.
    function automatic logic [8:0] map_ascii(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41};
            8'h32: r = {1'b1, 8'h42};
            8'h21: r = {1'b1, 8'h43};
            8'h23: r = {1'b1, 8'h44};
            8'h24: r = {1'b1, 8'h45};
            8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47};
            8'h33: r = {1'b1, 8'h48};
            8'h43: r = {1'b1, 8'h49};
            8'h3B: r = {1'b1, 8'h4A};
            8'h42: r = {1'b1, 8'h4B};
            8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D};
            8'h31: r = {1'b1, 8'h4E};
            8'h44: r = {1'b1, 8'h4F};
            8'h4D: r = {1'b1, 8'h50};
            8'h15: r = {1'b1, 8'h51};
            8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53};
            8'h2C: r = {1'b1, 8'h54};
            8'h3C: r = {1'b1, 8'h55};
            8'h2A: r = {1'b1, 8'h56};
            8'h1D: r = {1'b1, 8'h57};
            8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59};
            8'h1A: r = {1'b1, 8'h5A};
            8'h45: r = {1'b1, 8'h30};
            8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};
            8'h29: r = {1'b1, 8'h20};
            8'h5A: r = {1'b1, 8'h0D};
            8'h66: r = {1'b1, 8'h08};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Classify the settled word and decide whether a character is pushed.
    always_comb begin
        hi        = cand[15:8];
        lo        = cand[7:0];
        is_prefix = (lo == 8'hF0) || (lo == 8'hE0);
        is_break  = !is_prefix && (hi == 8'hF0);
        is_make   = !is_prefix && (hi != 8'hF0) && (hi != 8'hE0);
        new_make  = is_make && (lo != held_code);
        map_res   = map_ascii(lo);
        full      = (fifo_count == DEPTH_C);
        valid     = (fifo_count != 4'd0);
        pop       = rd_en && valid;
        push      = (state == S_DECODE) && new_make && map_res[8];
        data_out  = valid ? mem[rd_ptr] : 8'h00;
    end

    // Settling FSM plus the held-key tracking updated on decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            last_word <= 16'h0000;
            cand      <= 16'h0000;
            cnt       <= '0;
            key_down  <= 1'b0;
            held_code <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_in != last_word) begin
                        cand  <= key_in;
                        cnt   <= '0;
                        state <= S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (key_in != cand) begin
                        cand <= key_in;
                        cnt  <= '0;
                        if (key_in == last_word) begin
                            state <= S_IDLE;
                        end
                    end else if (cnt == CNT_MAX) begin
                        state <= S_DECODE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    last_word <= cand;
                    if (is_break && (lo == held_code)) begin
                        key_down  <= 1'b0;
                        held_code <= 8'h00;
                    end else if (new_make) begin
                        key_down  <= 1'b1;
                        held_code <= lo;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            if (push && (!full || pop)) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !full && !pop) begin
                fifo_count <= fifo_count + 4'd1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 4'd1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Character storage; contents are meaningless while the count is zero.
    always_ff @(posedge clk) begin
        if (push && (!full || pop)) begin
            mem[wr_ptr] <= map_res[7:0];
        end
    end

endmodule
